chart_note_sequencer: RTL and testbench

- Producer side of the note-event interface that the display consumes (fret, fret_time, fret_en); the per-string renderers are the reader.
- Walks a song chart stored in a synchronous-read ROM and compares each record's note time against song_time.
- Offers a note to the display once it falls inside the lookahead window, using a valid/ready handshake.
- Skips notes that are already too late, and flags completion at the end-of-chart marker.

---
 rtl/chart_note_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_chart_note_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/chart_note_sequencer.sv
// Chart note sequencer: walks a song chart held in a synchronous-read ROM and
// offers each upcoming note to the display over a valid/ready handshake.
module chart_note_sequencer #(
    parameter int          ADDR_W      = 12,
    parameter logic [15:0] LOOKAHEAD   = 16'd2000,
    parameter logic [15:0] MISS_WINDOW = 16'd200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    input  logic [15:0]       song_time,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [51:0]       rom_data,
    output logic [29:0]       fret,
    output logic [15:0]       fret_time,
    output logic [5:0]        fret_en,
    output logic              note_valid,
    input  logic              note_ready,
    output logic [7:0]        skipped_count,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_OFFER = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [51:0]         rec_q, rec_d;
    logic [29:0]         fret_q, fret_d;
    logic [15:0]         fret_time_q, fret_time_d;
    logic [5:0]          fret_en_q, fret_en_d;
    logic                note_valid_q, note_valid_d;
    logic [7:0]          skipped_q, skipped_d;
    logic                done_q, done_d;

    logic [15:0]         rec_time_s;
    logic [29:0]         rec_fret_s;
    logic [5:0]          rec_en_s;
    logic                late_s;
    logic                in_window_s;
    logic                at_last_s;
    logic [7:0]          skip_inc_s;

    assign rec_time_s = rec_q[51:36];
    assign rec_fret_s = rec_q[35:6];
    assign rec_en_s   = rec_q[5:0];

    // 17-bit compares so note_time+MISS_WINDOW and song_time+LOOKAHEAD never wrap
    assign late_s      = ({1'b0, song_time} > ({1'b0, rec_time_s} + {1'b0, MISS_WINDOW}));
    assign in_window_s = ({1'b0, rec_time_s} <= ({1'b0, song_time} + {1'b0, LOOKAHEAD}));
    assign at_last_s   = (rom_addr_q == LAST_ADDR);
    assign skip_inc_s  = (skipped_q == 8'd255) ? skipped_q : (skipped_q + 8'd1);

    // Next-state and output decode; start overrides everything else
    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        rec_d        = rec_q;
        fret_d       = fret_q;
        fret_time_d  = fret_time_q;
        fret_en_d    = fret_en_q;
        note_valid_d = note_valid_q;
        skipped_d    = skipped_q;
        done_d       = done_q;

        if (start) begin
            state_d      = S_FETCH;
            rom_addr_d   = {ADDR_W{1'b0}};
            done_d       = 1'b0;
            skipped_d    = 8'd0;
            note_valid_d = 1'b0;
            fret_en_d    = 6'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_FETCH: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    rec_d   = rom_data;
                    state_d = S_HOLD;
                end
                S_HOLD: begin
                    if (rec_en_s == 6'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (late_s) begin
                        skipped_d = skip_inc_s;
                        if (at_last_s) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            rom_addr_d = rom_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                            state_d    = S_FETCH;
                        end
                    end else if (in_window_s && !pause) begin
                        fret_d       = rec_fret_s;
                        fret_time_d  = rec_time_s;
                        fret_en_d    = rec_en_s;
                        note_valid_d = 1'b1;
                        state_d      = S_OFFER;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                S_OFFER: begin
                    // fret/fret_time stay put after the transfer; only the enables clear
                    if (note_valid_q && note_ready) begin
                        note_valid_d = 1'b0;
                        fret_en_d    = 6'd0;
                        if (at_last_s) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            rom_addr_d = rom_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                            state_d    = S_FETCH;
                        end
                    end else begin
                        state_d = S_OFFER;
                    end
                end
                S_DONE: begin
                    done_d       = 1'b1;
                    note_valid_d = 1'b0;
                    fret_en_d    = 6'd0;
                end
                default: begin
                    state_d      = S_IDLE;
                    note_valid_d = 1'b0;
                    fret_en_d    = 6'd0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rom_addr_q   <= {ADDR_W{1'b0}};
            rec_q        <= 52'd0;
            fret_q       <= 30'd0;
            fret_time_q  <= 16'd0;
            fret_en_q    <= 6'd0;
            note_valid_q <= 1'b0;
            skipped_q    <= 8'd0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            rec_q        <= rec_d;
            fret_q       <= fret_d;
            fret_time_q  <= fret_time_d;
            fret_en_q    <= fret_en_d;
            note_valid_q <= note_valid_d;
            skipped_q    <= skipped_d;
            done_q       <= done_d;
        end
    end

    assign rom_addr      = rom_addr_q;
    assign fret          = fret_q;
    assign fret_time     = fret_time_q;
    assign fret_en       = fret_en_q;
    assign note_valid    = note_valid_q;
    assign skipped_count = skipped_q;
    assign done          = done_q;

endmodule

// File: tb/tb_chart_note_sequencer.sv
// Directed bench for chart_note_sequencer with a behavioural synchronous-read chart ROM.
module tb_chart_note_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        pause;
    logic [15:0] song_time;
    logic [11:0] rom_addr;
    logic [51:0] rom_data;
    logic [29:0] fret;
    logic [15:0] fret_time;
    logic [5:0]  fret_en;
    logic        note_valid;
    logic        note_ready;
    logic [7:0]  skipped_count;
    logic        done;

    logic [51:0] rom_mem [0:4095];
    int vectors;
    int miscompares;

    chart_note_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
        .song_time(song_time), .rom_addr(rom_addr), .rom_data(rom_data),
        .fret(fret), .fret_time(fret_time), .fret_en(fret_en),
        .note_valid(note_valid), .note_ready(note_ready),
        .skipped_count(skipped_count), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    function automatic logic [51:0] rec(input logic [15:0] t, input logic [29:0] f, input logic [5:0] e);
        return {t, f, e};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom_mem[i] = 52'd0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        vectors++; if (rom_addr !== 12'd0) begin miscompares++; $display("FAIL reset_addr got %0d want 0", rom_addr); end
        vectors++; if (note_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", note_valid); end
        vectors++; if (fret !== 30'd0) begin miscompares++; $display("FAIL reset_fret got %h want 0", fret); end
        vectors++; if (fret_time !== 16'd0) begin miscompares++; $display("FAIL reset_time got %0d want 0", fret_time); end
        vectors++; if (fret_en !== 6'd0) begin miscompares++; $display("FAIL reset_en got %b want 0", fret_en); end
        vectors++; if (skipped_count !== 8'd0) begin miscompares++; $display("FAIL reset_skip got %0d want 0", skipped_count); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        repeat (3) tick();
        vectors++; if (note_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid got %b want 0", note_valid); end
    endtask

    task automatic test_basic();
        clear_rom();
        rom_mem[0] = rec(16'd100, 30'd3, 6'b000001);
        song_time = 16'd0; note_ready = 1'b1; pause = 1'b0;
        pulse_start();
        repeat (2) tick();
        vectors++; if (note_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early got %b want 0", note_valid); end
        tick();
        vectors++; if (note_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %b want 1", note_valid); end
        vectors++; if (fret_time !== 16'd100) begin miscompares++; $display("FAIL basic_time got %0d want 100", fret_time); end
        vectors++; if (fret !== 30'd3) begin miscompares++; $display("FAIL basic_fret got %h want 3", fret); end
        vectors++; if (fret_en !== 6'b000001) begin miscompares++; $display("FAIL basic_en got %b want 000001", fret_en); end
        tick();
        vectors++; if (note_valid !== 1'b0) begin miscompares++; $display("FAIL basic_xfer_valid got %b want 0", note_valid); end
        vectors++; if (fret_en !== 6'd0) begin miscompares++; $display("FAIL basic_xfer_en got %b want 0", fret_en); end
        vectors++; if (fret !== 30'd3) begin miscompares++; $display("FAIL basic_hold_fret got %h want 3", fret); end
        vectors++; if (rom_addr !== 12'd1) begin miscompares++; $display("FAIL basic_addr got %0d want 1", rom_addr); end
        repeat (3) tick();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL basic_done got %b want 1", done); end
        vectors++; if (skipped_count !== 8'd0) begin miscompares++; $display("FAIL basic_skip got %0d want 0", skipped_count); end
        note_ready = 1'b0;
    endtask

    task automatic test_window_and_stall();
        logic [15:0] ramp [0:3];
        ramp[0] = 16'd0; ramp[1] = 16'd1000; ramp[2] = 16'd2000; ramp[3] = 16'd2999;
        clear_rom();
        rom_mem[0] = rec(16'd5000, 30'h2AB, 6'b000010);
        song_time = 16'd0; note_ready = 1'b0; pause = 1'b0;
        pulse_start();
        repeat (2) tick();
        for (int i = 0; i < 4; i++) begin
            song_time = ramp[i];
            tick();
            vectors++; if (note_valid !== 1'b0) begin miscompares++; $display("FAIL win_early t=%0d got %b want 0", ramp[i], note_valid); end
        end
        song_time = 16'd3000; pause = 1'b1;
        repeat (3) tick();
        vectors++; if (note_valid !== 1'b0) begin miscompares++; $display("FAIL win_paused got %b want 0", note_valid); end
        pause = 1'b0;
        tick();
        vectors++; if (note_valid !== 1'b1) begin miscompares++; $display("FAIL win_offer got %b want 1", note_valid); end
        vectors++; if (fret_time !== 16'd5000) begin miscompares++; $display("FAIL win_time got %0d want 5000", fret_time); end
        for (int i = 0; i < 10; i++) begin
            pause = i[0];
            tick();
            vectors++; if (note_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid c=%0d got %b want 1", i, note_valid); end
            vectors++; if (fret !== 30'h2AB) begin miscompares++; $display("FAIL stall_fret c=%0d got %h want 2ab", i, fret); end
            vectors++; if (fret_time !== 16'd5000) begin miscompares++; $display("FAIL stall_time c=%0d got %0d want 5000", i, fret_time); end
            vectors++; if (fret_en !== 6'b000010) begin miscompares++; $display("FAIL stall_en c=%0d got %b want 000010", i, fret_en); end
        end
        pause = 1'b0; note_ready = 1'b1;
        tick();
        note_ready = 1'b0;
        vectors++; if (note_valid !== 1'b0) begin miscompares++; $display("FAIL stall_xfer got %b want 0", note_valid); end
        vectors++; if (rom_addr !== 12'd1) begin miscompares++; $display("FAIL stall_addr got %0d want 1", rom_addr); end
        vectors++; if (fret_time !== 16'd5000) begin miscompares++; $display("FAIL stall_hold_time got %0d want 5000", fret_time); end
        tick();
        vectors++; if (note_valid !== 1'b0) begin miscompares++; $display("FAIL stall_single got %b want 0", note_valid); end
        repeat (2) tick();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL stall_done got %b want 1", done); end
    endtask

    task automatic test_skip();
        int guard;
        clear_rom();
        rom_mem[0] = rec(16'd100, 30'h11, 6'h01);
        rom_mem[1] = rec(16'd700, 30'h12, 6'h01);
        rom_mem[2] = rec(16'd950, 30'h15, 6'h3F);
        song_time = 16'd1000; note_ready = 1'b0; pause = 1'b0;
        pulse_start();
        repeat (8) tick();
        vectors++; if (note_valid !== 1'b0) begin miscompares++; $display("FAIL skip_early got %b want 0", note_valid); end
        vectors++; if (skipped_count !== 8'd2) begin miscompares++; $display("FAIL skip_cnt got %0d want 2", skipped_count); end
        tick();
        vectors++; if (note_valid !== 1'b1) begin miscompares++; $display("FAIL skip_offer got %b want 1", note_valid); end
        vectors++; if (fret_time !== 16'd950) begin miscompares++; $display("FAIL skip_time got %0d want 950", fret_time); end
        vectors++; if (fret_en !== 6'h3F) begin miscompares++; $display("FAIL skip_en got %b want 111111", fret_en); end
        vectors++; if (rom_addr !== 12'd2) begin miscompares++; $display("FAIL skip_addr got %0d want 2", rom_addr); end
        clear_rom();
        for (int i = 0; i < 300; i++) rom_mem[i] = rec(16'd100, 30'd0, 6'b000001);
        pulse_start();
        vectors++; if (skipped_count !== 8'd0) begin miscompares++; $display("FAIL sat_clear got %0d want 0", skipped_count); end
        guard = 0;
        while (done !== 1'b1 && guard < 2000) begin
            tick();
            guard++;
        end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL sat_timeout done got %b want 1", done); end
        vectors++; if (skipped_count !== 8'd255) begin miscompares++; $display("FAIL sat_cnt got %0d want 255", skipped_count); end
        vectors++; if (rom_addr !== 12'd300) begin miscompares++; $display("FAIL sat_addr got %0d want 300", rom_addr); end
    endtask

    task automatic load_two_notes();
        clear_rom();
        rom_mem[0] = rec(16'd100, 30'd7, 6'b000001);
        rom_mem[1] = rec(16'd200, 30'd9, 6'b000010);
    endtask

    task automatic test_restart();
        load_two_notes();
        song_time = 16'd0; note_ready = 1'b0; pause = 1'b0;
        pulse_start();
        repeat (3) tick();
        vectors++; if (fret_time !== 16'd100) begin miscompares++; $display("FAIL rs_first got %0d want 100", fret_time); end
        note_ready = 1'b1;
        tick();
        note_ready = 1'b0;
        repeat (3) tick();
        vectors++; if (note_valid !== 1'b1) begin miscompares++; $display("FAIL rs_second_valid got %b want 1", note_valid); end
        vectors++; if (fret_time !== 16'd200) begin miscompares++; $display("FAIL rs_second_time got %0d want 200", fret_time); end
        start = 1'b1; note_ready = 1'b1;
        tick();
        start = 1'b0; note_ready = 1'b0;
        vectors++; if (note_valid !== 1'b0) begin miscompares++; $display("FAIL rs_withdraw got %b want 0", note_valid); end
        vectors++; if (rom_addr !== 12'd0) begin miscompares++; $display("FAIL rs_addr got %0d want 0", rom_addr); end
        vectors++; if (fret_en !== 6'd0) begin miscompares++; $display("FAIL rs_en got %b want 0", fret_en); end
        repeat (3) tick();
        vectors++; if (note_valid !== 1'b1) begin miscompares++; $display("FAIL rs_replay_valid got %b want 1", note_valid); end
        vectors++; if (fret_time !== 16'd100) begin miscompares++; $display("FAIL rs_replay_time got %0d want 100", fret_time); end
        vectors++; if (fret !== 30'd7) begin miscompares++; $display("FAIL rs_replay_fret got %h want 7", fret); end
    endtask

    task automatic test_async_reset();
        load_two_notes();
        song_time = 16'd0; note_ready = 1'b1; pause = 1'b0;
        pulse_start();
        repeat (5) tick();
        note_ready = 1'b0;
        vectors++; if (fret !== 30'd7) begin miscompares++; $display("FAIL ar_pre_fret got %h want 7", fret); end
        #3;
        rst_n = 1'b0;
        #1;
        vectors++; if (rom_addr !== 12'd0) begin miscompares++; $display("FAIL ar_addr got %0d want 0", rom_addr); end
        vectors++; if (fret !== 30'd0) begin miscompares++; $display("FAIL ar_fret got %h want 0", fret); end
        vectors++; if (fret_time !== 16'd0) begin miscompares++; $display("FAIL ar_time got %0d want 0", fret_time); end
        vectors++; if (note_valid !== 1'b0) begin miscompares++; $display("FAIL ar_valid got %b want 0", note_valid); end
        #2;
        rst_n = 1'b1;
        repeat (10) tick();
        vectors++; if (note_valid !== 1'b0) begin miscompares++; $display("FAIL ar_no_offer got %b want 0", note_valid); end
        vectors++; if (rom_addr !== 12'd0) begin miscompares++; $display("FAIL ar_idle_addr got %0d want 0", rom_addr); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; start = 1'b0; pause = 1'b0; song_time = 16'd0; note_ready = 1'b0;
        clear_rom();
        test_reset();
        test_basic();
        test_window_and_stall();
        test_skip();
        test_restart();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
